// File: rtl/spi_slave.sv
// spi_slave: SPI target, CPOL = 0 / CPHA = 1.
// SCK/SS/MOSI are resynchronized into clk and edge-detected there; MISO is
// shifted out on SCK rising edges and MOSI is captured on SCK falling edges.
// Fabric side: spi_tx_* follows valid/ready; spi_rx_* is a valid-only strobe.
//
// Handshake: a TX byte moves from fabric into the holding register on every
// rising clk edge where spi_tx_valid and spi_tx_ready are both 1; spi_tx_data
// must be stable while spi_tx_valid is 1, and spi_tx_ready never depends
// combinationally on spi_tx_valid. spi_rx_valid is a single-cycle strobe with
// no backpressure.
`timescale 1ns/1ps
module spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       SCK_I,
  input  logic       SS_I,
  input  logic       IO0_I,
  output logic       IO1_O,
  output logic       IO1_T,
  input  logic [7:0] spi_tx_data,
  input  logic       spi_tx_valid,
  output logic       spi_tx_ready,
  output logic [7:0] spi_rx_data,
  output logic       spi_rx_valid,
  output logic       tx_underrun,
  output logic       state_dbg
);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_ACTIVE = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] ss_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic sck_s;
  logic ss_s;
  logic mosi_s;
  logic sck_d;
  logic sck_rise;
  logic sck_fall;

  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic       rx_done;
  logic [7:0] tx_hold;
  logic       tx_full;
  logic       tx_full_nxt;
  logic [7:0] tx_shift;
  logic       tx_take;

  logic byte_start;
  logic shift_rise;
  logic rx_edge;
  logic in_idle;

  assign sck_s  = sck_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  assign sck_rise = sck_s & ~sck_d;
  assign sck_fall = ~sck_s & sck_d;

  assign state_dbg = state;

  // Synchronizer chains plus the one-cycle SCK delay used for edge detection.
  // SS resets high so the core starts deselected.
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_sync  <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sck_d     <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK_I};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], SS_I};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], IO0_I};
      sck_d     <= sck_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: follow the synchronized slave select.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!ss_s) state_nxt = S_ACTIVE;
      S_ACTIVE: if (ss_s)  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs: SCK edges only matter while selected; bit 0 rise starts a byte.
  always_comb begin
    in_idle    = 1'b1;
    byte_start = 1'b0;
    shift_rise = 1'b0;
    rx_edge    = 1'b0;
    if (state == S_ACTIVE) begin
      in_idle    = 1'b0;
      byte_start = sck_rise & (bit_cnt == 3'd0);
      shift_rise = sck_rise & (bit_cnt != 3'd0);
      rx_edge    = sck_fall;
    end
  end

  // Holding-register occupancy: a fabric write fills it, a byte start drains it.
  // A write can only happen while empty, so it never collides with a drain.
  always_comb begin
    tx_take     = spi_tx_valid & spi_tx_ready;
    tx_full_nxt = tx_full;
    if (byte_start) tx_full_nxt = 1'b0;
    if (tx_take)    tx_full_nxt = 1'b1;
  end

  // TX path: holding register, shift register, MISO and underrun strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_hold      <= 8'h00;
      tx_full      <= 1'b0;
      spi_tx_ready <= 1'b0;
      tx_shift     <= 8'h00;
      tx_underrun  <= 1'b0;
      IO1_O        <= 1'b0;
      IO1_T        <= 1'b1;
    end else begin
      if (tx_take) tx_hold <= spi_tx_data;
      tx_full      <= tx_full_nxt;
      spi_tx_ready <= ~tx_full_nxt;
      if (byte_start)      tx_shift <= tx_full ? tx_hold : 8'h00;
      else if (shift_rise) tx_shift <= {tx_shift[6:0], 1'b0};
      tx_underrun  <= byte_start & ~tx_full;
      IO1_O        <= tx_shift[7];
      IO1_T        <= ss_s;
    end
  end

  // RX path: bit counter and shifter; a completed byte is published one cycle
  // before its strobe. Deselect wipes any partial byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt      <= 3'd0;
      rx_shift     <= 7'd0;
      rx_done      <= 1'b0;
      spi_rx_data  <= 8'h00;
      spi_rx_valid <= 1'b0;
    end else begin
      rx_done      <= 1'b0;
      spi_rx_valid <= rx_done;
      if (in_idle) begin
        bit_cnt  <= 3'd0;
        rx_shift <= 7'd0;
      end else if (rx_edge) begin
        rx_shift <= {rx_shift[5:0], mosi_s};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          spi_rx_data <= {rx_shift, mosi_s};
          rx_done     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/spi_slave.md
# spi_slave

SPI slave (target) core, fixed CPOL = 0 / CPHA = 1, the counterpart of the team's SPI master core on the same bus. Samples SCK/SS/MOSI asynchronously into the `clk` domain, drives MISO, and exchanges bytes with fabric logic over an AXI4-Stream-style TX interface and a valid-only RX interface. It is used where the FPGA is controlled by an external SPI host, for example a board MCU.

## Interface
- SYNC_STAGES, 2, synchronizer depth for SCK_I/SS_I/IO0_I, range 2..4.
- clk  in  1  fabric clock; must be ≥ 8× SCK frequency.
- rst  in  1  reset; synchronous, active-high.
- SCK_I  in  1  SPI clock from the master, asynchronous.
- SS_I  in  1  slave select, active-low, asynchronous.
- IO0_I  in  1  MOSI.
- IO1_O  out  1  MISO data.
- IO1_T  out  1  MISO tri-state enable, 1 = high-Z.
- spi_tx_data  in  8  next byte to return to the master.
- spi_tx_valid  in  1  spi_tx_data valid.
- spi_tx_ready  out  1  holding register empty.
- spi_rx_data  out  8  byte received from MOSI, MSB first.
- spi_rx_valid  out  1  one-cycle strobe; no backpressure.
- tx_underrun  out  1  one-cycle strobe: a byte started with an empty holding register.

## Operation
- **Synchronizers:** SCK_I, SS_I and IO0_I each pass through SYNC_STAGES flops (sck_s, ss_s, mosi_s).
  - sck_rise = sck_s & !sck_d; sck_fall = !sck_s & sck_d.
  - sck_d is sck_s delayed by one cycle.
- **States:**
  - S_IDLE (ss_s = 1) → S_ACTIVE when ss_s = 0.
  - S_ACTIVE → S_IDLE when ss_s = 1.
  - Entering S_ACTIVE clears bit_cnt (3 bits) and rx_shift.
  - SCK edges in S_IDLE are ignored.
- **TX holding register:**
  - tx_hold plus a tx_full flag; spi_tx_ready = !tx_full (registered).
  - A transfer (valid & ready) writes tx_hold and sets tx_full.
- **Byte start:** sck_rise in S_ACTIVE with bit_cnt = 0.
  - If tx_full: tx_shift ← tx_hold and tx_full clears.
  - Otherwise: tx_shift ← 0x00 and tx_underrun pulses.
  - A TX transfer in the same cycle lands in tx_hold and is used for the next byte.
- **Other sck_rise in S_ACTIVE:** tx_shift ← {tx_shift[6:0], 0}. IO1_O = tx_shift[7] (registered).
- **sck_fall in S_ACTIVE:** rx_shift ← {rx_shift[6:0], mosi_s}; bit_cnt increments and wraps 7 → 0.
  - On the fall with bit_cnt = 7: spi_rx_data ← {rx_shift[6:0], mosi_s} and spi_rx_valid pulses on the next cycle.
- **Back-to-back bytes:** continuous within one SS-low window; the byte count is unlimited.
- **IO1_T:** = ss_s (registered), so MISO is high-Z whenever the slave is deselected.

## Timing
- **Reset values:**
  - IO1_T = 1, IO1_O = 0, spi_tx_ready = 0, spi_rx_valid = 0, spi_rx_data = 0x00, tx_underrun = 0.
  - tx_full = 0, bit_cnt = 0, state = S_IDLE.
- spi_tx_ready is 1 from the first cycle after rst deasserts.
- **Latency:**
  - SCK_I rising pin → IO1_O change: SYNC_STAGES + 2 clk.
  - Last SCK falling pin → spi_rx_valid: SYNC_STAGES + 2 clk.
- MOSI uses the same synchronizer depth as SCK, so it is sampled at the delayed falling edge. The master must hold MOSI ≥ SYNC_STAGES + 2 clk after each falling edge.
- **SS high mid-byte:**
  - The partial RX byte is discarded with no spi_rx_valid, and bit_cnt is cleared.
  - The byte already in tx_shift counts as consumed.
  - tx_hold and tx_full are kept.
- rst mid-transfer returns to reset values within one cycle; tx_hold is emptied.
- A byte completing while an earlier spi_rx_valid is pending is impossible, given the clock ratio of 8 or more.

## Test plan
- **Single byte:** preload 0xA5; master sends 0x3C at SCK = clk/8 → master reads 0xA5; spi_rx_data = 0x3C with exactly one spi_rx_valid; tx_underrun stays 0.
- **Streaming:** preload 0x11; refill 0x22 and 0x33 as ready rises; master sends 0x01 0x02 0x03 in one SS window → MISO returns 0x11 0x22 0x33; three rx strobes carry 0x01, 0x02, 0x03.
- **Underrun:** no TX data; master sends 0xFF → MISO returns 0x00; tx_underrun pulses once at the first rising edge; rx byte = 0xFF.
- **Abort:** SS deasserts after 5 SCK cycles → no spi_rx_valid and IO1_T = 1; the next full byte receives correctly, starting from bit 7.
- **Idle noise:** SCK toggles while SS is high → no rx strobes, IO1_T stays 1, and tx_full is unchanged.
- **Reset mid-byte:** assert rst after 3 bits → all outputs take reset values and spi_tx_ready returns to 1 one cycle after rst deasserts.
